pipo_rr_arbiter: RTL and testbench

- Shares one N-bit parallel-in/parallel-out register between M requesters.
- Requests are arbitered round-robin. The grant is a registered one-hot, and the winner's word is loaded with an enable pulse.
- After each load the value is held for HOLD_CYC cycles so consumers can sample it. Only then is another load allowed.
- Sits between several producer blocks and the shared PIPO datapath. It sequences the register's `en` and `pin`.

---
 rtl/pipo_arb_pkg.sv | 25 ++
 rtl/pipo_reg_n.sv | 27 ++
 rtl/pipo_rr_arbiter.sv | 163 ++++++++++++++++
 tb/tb_pipo_rr_arbiter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pipo_arb_pkg.sv
// Shared types and constants for the round-robin PIPO register arbiter.
package pipo_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam int DEF_N        = 4;
    localparam int DEF_M        = 4;
    localparam int DEF_HOLD_CYC = 2;

    // Ceiling log2; returns 0 for values of 0 or 1.
    function automatic int clog2(input int value);
        int v;
        int r;
        r = 0;
        for (v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/pipo_reg_n.sv
// N-bit parallel-in/parallel-out register with async active-low clear and load enable.
module pipo_reg_n #(
    parameter int N = 4
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;

    // Storage: cleared asynchronously, loaded when enabled.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= {N{1'b0}};
        end else if (i_en) begin
            r_q <= i_d;
        end else begin
            r_q <= r_q;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/pipo_rr_arbiter.sv
// Round-robin arbiter sequencing loads of M producers into one shared PIPO register,
// holding each loaded value stable for HOLD_CYC cycles before the next load.
module pipo_rr_arbiter
    import pipo_arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int M        = DEF_M,
    parameter int HOLD_CYC = DEF_HOLD_CYC
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [M-1:0]          req,
    input  logic [M*N-1:0]        din,
    output logic [M-1:0]          gnt,
    output logic                  ld_en,
    output logic [N-1:0]          ld_data,
    output logic [N-1:0]          q,
    output logic [clog2(M)-1:0]   q_owner,
    output logic                  done,
    output logic                  busy
);

    localparam int SEL_W = clog2(M);
    localparam int CNT_W = (clog2(HOLD_CYC + 1) > 0) ? clog2(HOLD_CYC + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = (HOLD_CYC > 0) ? CNT_W'(HOLD_CYC - 1) : {CNT_W{1'b0}};
    localparam logic [SEL_W-1:0] PTR_INIT = SEL_W'(M - 1);
    localparam logic [M-1:0]     ONE_M    = {{(M-1){1'b0}}, 1'b1};

    state_t             r_state;
    state_t             w_next_state;
    logic [SEL_W-1:0]   r_ptr;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   r_q_owner;
    logic [SEL_W-1:0]   w_winner;
    logic [M-1:0]       r_gnt;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_done;
    logic               w_load_ok;
    logic [N-1:0]       w_ld_data;
    logic [N-1:0]       w_q;

    // First requester after p in circular order; explicit modulo keeps non-power-of-2 M correct.
    function automatic logic [SEL_W-1:0] rr_pick(input logic [M-1:0] r, input logic [SEL_W-1:0] p);
        logic [SEL_W-1:0] pick;
        logic [SEL_W-1:0] cand;
        logic             found;
        pick  = p;
        found = 1'b0;
        for (int k = 1; k <= M; k++) begin
            cand = SEL_W'((int'(p) + k) % M);
            if (!found && r[cand]) begin
                pick  = cand;
                found = 1'b1;
            end
        end
        return pick;
    endfunction

    assign w_winner  = rr_pick(req, r_ptr);
    assign w_load_ok = (r_state == LOAD) && req[r_sel];

    // Word selection as an AND-OR mux over the packed producer slices.
    always_comb begin
        w_ld_data = {N{1'b0}};
        for (int i = 0; i < M; i++) begin
            w_ld_data = w_ld_data | (din[i*N +: N] & {N{r_sel == SEL_W'(i)}});
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic; a withdrawn request aborts LOAD straight back to IDLE.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: begin
                if (|req) begin
                    w_next_state = LOAD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            LOAD: begin
                if (w_load_ok && (HOLD_CYC != 0)) begin
                    w_next_state = HOLD;
                end else begin
                    w_next_state = IDLE;
                end
            end
            HOLD: begin
                if (r_cnt == {CNT_W{1'b0}}) begin
                    w_next_state = IDLE;
                end else begin
                    w_next_state = HOLD;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // Grant, pointer, owner, hold counter and completion pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ptr     <= PTR_INIT;
            r_sel     <= {SEL_W{1'b0}};
            r_q_owner <= {SEL_W{1'b0}};
            r_gnt     <= {M{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (|req) begin
                        r_sel <= w_winner;
                        r_gnt <= ONE_M << w_winner;
                    end
                end
                LOAD: begin
                    r_gnt <= {M{1'b0}};
                    if (w_load_ok) begin
                        r_q_owner <= r_sel;
                        r_ptr     <= r_sel;
                        r_done    <= 1'b1;
                        r_cnt     <= CNT_INIT;
                    end
                end
                HOLD: begin
                    if (r_cnt != {CNT_W{1'b0}}) begin
                        r_cnt <= r_cnt - CNT_W'(1);
                    end
                end
                default: r_gnt <= {M{1'b0}};
            endcase
        end
    end

    pipo_reg_n #(
        .N (N)
    ) u_reg (
        .i_clk   (clk),
        .i_rst_n (rst),
        .i_en    (w_load_ok),
        .i_d     (w_ld_data),
        .o_q     (w_q)
    );

    assign gnt     = r_gnt;
    assign ld_en   = w_load_ok;
    assign ld_data = w_ld_data;
    assign q       = w_q;
    assign q_owner = r_q_owner;
    assign done    = r_done;
    assign busy    = (r_state != IDLE);

endmodule

// File: tb/tb_pipo_rr_arbiter.sv
// Self-checking bench for pipo_rr_arbiter (N=4, M=4, HOLD_CYC=2): directed scenarios plus
// a randomized run against a timeline-level reference model.
module tb_pipo_rr_arbiter;

    localparam int N    = 4;
    localparam int M    = 4;
    localparam int HOLD = 2;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [3:0]   req = 4'b0000;
    logic [15:0]  din = 16'h0000;
    logic [3:0]   gnt;
    logic         ld_en;
    logic [3:0]   ld_data;
    logic [3:0]   q;
    logic [1:0]   q_owner;
    logic         done;
    logic         busy;

    int checks = 0;
    int errors = 0;

    pipo_rr_arbiter #(.N(N), .M(M), .HOLD_CYC(HOLD)) dut (
        .clk     (clk),
        .rst     (rst),
        .req     (req),
        .din     (din),
        .gnt     (gnt),
        .ld_en   (ld_en),
        .ld_data (ld_data),
        .q       (q),
        .q_owner (q_owner),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Winner = first requester after p going around the ring, found in a doubled request vector.
    function automatic int ref_pick(input logic [3:0] r, input int p);
        logic [7:0] dbl;
        dbl = {r, r} >> (p + 1);
        for (int o = 0; o < 4; o++) begin
            if (dbl[3'(o)]) return (p + 1 + o) % 4;
        end
        return -1;
    endfunction

    task automatic test_reset();
        logic [3:0] d0;
        rst = 1'b0; req = 4'b1111; din = 16'($urandom); d0 = din[3:0];
        tick(); tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL rst_gnt got=%b exp=0000", gnt); end
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL rst_q got=%h exp=0", q); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b exp=0", busy); end
        rst = 1'b1;
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL rst_first_gnt got=%b exp=0001", gnt); end
        checks++; if (ld_en !== 1'b1) begin errors++; $display("FAIL rst_first_lden got=%b exp=1", ld_en); end
        tick();
        checks++; if (q !== d0) begin errors++; $display("FAIL rst_first_q got=%h exp=%h", q, d0); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL rst_first_done got=%b exp=1", done); end
        req = 4'b0000;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_idle_busy got=%b exp=0", busy); end
    endtask

    task automatic test_single();
        din = 16'($urandom); din[11:8] = 4'hA; req = 4'b0100;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt0 got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_busy0 got=%b exp=0", busy); end
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL single_gnt got=%b exp=0100", gnt); end
        checks++; if (ld_en !== 1'b1) begin errors++; $display("FAIL single_lden got=%b exp=1", ld_en); end
        checks++; if (ld_data !== 4'hA) begin errors++; $display("FAIL single_lddata got=%h exp=a", ld_data); end
        tick();
        checks++; if (q !== 4'hA) begin errors++; $display("FAIL single_q got=%h exp=a", q); end
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL single_done got=%b exp=1", done); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL single_gnt_clr got=%b exp=0000", gnt); end
        checks++; if (q_owner !== 2'd2) begin errors++; $display("FAIL single_owner got=%0d exp=2", q_owner); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_hold1 got=%b exp=1", busy); end
        req = 4'b0000;
        tick();
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL single_done_pulse got=%b exp=0", done); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_hold2 got=%b exp=1", busy); end
        tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle got=%b exp=0", busy); end
    endtask

    task automatic test_all_continuous();
        logic [3:0] exp_g;
        logic [3:0] exp_q;
        rst = 1'b0; tick(); rst = 1'b1;
        din = 16'h4321; req = 4'b1111;
        for (int c = 1; c <= 18; c++) begin
            tick();
            exp_g = (((c - 1) % 4 == 0) && (c <= 17)) ? (4'b0001 << (((c - 1) / 4) % 4)) : 4'b0000;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL all_gnt c=%0d got=%b exp=%b", c, gnt, exp_g); end
            if ((c >= 2) && ((c - 2) % 4 == 0)) begin
                exp_q = 4'(((c - 2) / 4) % 4 + 1);
                checks++; if (q !== exp_q) begin errors++; $display("FAIL all_q c=%0d got=%h exp=%h", c, q, exp_q); end
                checks++; if (done !== 1'b1) begin errors++; $display("FAIL all_done c=%0d got=%b exp=1", c, done); end
            end
        end
        req = 4'b0000;
        tick(); tick();
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL all_idle got=%b exp=0", busy); end
    endtask

    task automatic test_withdraw();
        logic [3:0] d1;
        req = 4'b0010; din = 16'($urandom);
        tick();
        req = 4'b0000;
        #1;
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wd_gnt got=%b exp=0010", gnt); end
        checks++; if (ld_en !== 1'b0) begin errors++; $display("FAIL wd_lden got=%b exp=0", ld_en); end
        tick();
        checks++; if (q !== 4'h1) begin errors++; $display("FAIL wd_q got=%h exp=1", q); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL wd_done got=%b exp=0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL wd_busy got=%b exp=0", busy); end
        req = 4'b0011; din = 16'($urandom); d1 = din[7:4];
        tick();
        checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL wd_ptr_kept got=%b exp=0010", gnt); end
        tick();
        checks++; if (q !== d1) begin errors++; $display("FAIL wd_reload_q got=%h exp=%h", q, d1); end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_midreset();
        logic [3:0] d0;
        din = 16'($urandom); din[11:8] = 4'hF; req = 4'b0100;
        tick();
        checks++; if (gnt !== 4'b0100) begin errors++; $display("FAIL mr_gnt got=%b exp=0100", gnt); end
        rst = 1'b0;
        #1;
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL mr_q_async got=%h exp=0", q); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mr_busy got=%b exp=0", busy); end
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL mr_gnt_clr got=%b exp=0000", gnt); end
        tick();
        checks++; if (q !== 4'h0) begin errors++; $display("FAIL mr_q_lost got=%h exp=0", q); end
        rst = 1'b1; req = 4'b1111; d0 = din[3:0];
        tick();
        checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL mr_first_gnt got=%b exp=0001", gnt); end
        tick();
        checks++; if (q !== d0) begin errors++; $display("FAIL mr_first_q got=%h exp=%h", q, d0); end
        req = 4'b0000;
        tick(); tick();
    endtask

    task automatic test_hold_req();
        logic [3:0] d3;
        din = 16'($urandom); d3 = din[15:12]; req = 4'b0001;
        tick();
        tick();
        req = 4'b1000;
        #1;
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_gnt1 got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL hold_busy1 got=%b exp=1", busy); end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_gnt2 got=%b exp=0000", gnt); end
        tick();
        checks++; if (gnt !== 4'b0000) begin errors++; $display("FAIL hold_gnt_idle got=%b exp=0000", gnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL hold_idle got=%b exp=0", busy); end
        tick();
        checks++; if (gnt !== 4'b1000) begin errors++; $display("FAIL hold_late_gnt got=%b exp=1000", gnt); end
        tick();
        checks++; if (q !== d3) begin errors++; $display("FAIL hold_late_q got=%h exp=%h", q, d3); end
        checks++; if (q_owner !== 2'd3) begin errors++; $display("FAIL hold_owner got=%0d exp=3", q_owner); end
        req = 4'b0000;
        tick(); tick();
    endtask

    // Random producers against a timeline model: when the arbiter is free, when a load lands,
    // what q holds and who owns it.
    task automatic test_random();
        int         m_free, m_gcyc, m_done_cyc, m_ptr, m_gw, m_owner;
        logic [3:0] m_q, pend, exp_g;
        bit         wd, exp_ld;
        req = 4'b0000; rst = 1'b0; tick(); rst = 1'b1;
        m_ptr = 3; m_q = 4'h0; m_owner = 0; m_free = 0; m_gcyc = -1; m_done_cyc = -1; m_gw = 0;
        pend = 4'b0000;
        for (int t = 0; t < 400; t++) begin
            din = 16'($urandom);
            for (int i = 0; i < 4; i++) begin
                if (!pend[i] && ($urandom_range(0, 3) == 0)) pend[i] = 1'b1;
            end
            wd  = (t == m_gcyc) && ($urandom_range(0, 7) == 0);
            req = pend;
            if (wd) req[m_gw] = 1'b0;
            #1;
            exp_g  = (t == m_gcyc) ? (4'b0001 << m_gw) : 4'b0000;
            exp_ld = (t == m_gcyc) && !wd;
            checks++; if (gnt !== exp_g) begin errors++; $display("FAIL rnd_gnt t=%0d got=%b exp=%b", t, gnt, exp_g); end
            checks++; if (ld_en !== exp_ld) begin errors++; $display("FAIL rnd_lden t=%0d got=%b exp=%b", t, ld_en, exp_ld); end
            checks++; if (done !== (t == m_done_cyc)) begin errors++; $display("FAIL rnd_done t=%0d got=%b exp=%b", t, done, (t == m_done_cyc)); end
            checks++; if (busy !== (t < m_free)) begin errors++; $display("FAIL rnd_busy t=%0d got=%b exp=%b", t, busy, (t < m_free)); end
            checks++; if (q !== m_q) begin errors++; $display("FAIL rnd_q t=%0d got=%h exp=%h", t, q, m_q); end
            checks++; if (q_owner !== 2'(m_owner)) begin errors++; $display("FAIL rnd_owner t=%0d got=%0d exp=%0d", t, q_owner, m_owner); end
            if (t == m_gcyc) begin
                checks++; if (ld_data !== din[m_gw*4 +: 4]) begin errors++; $display("FAIL rnd_lddata t=%0d got=%h exp=%h", t, ld_data, din[m_gw*4 +: 4]); end
                if (!wd) begin
                    m_q = din[m_gw*4 +: 4]; m_owner = m_gw; m_ptr = m_gw;
                    m_done_cyc = t + 1; m_free = t + 1 + HOLD;
                end else begin
                    m_free = t + 1;
                end
                pend[m_gw] = 1'b0;
            end else if ((t >= m_free) && (req != 4'b0000)) begin
                m_gw = ref_pick(req, m_ptr); m_gcyc = t + 1; m_free = t + 2;
            end
            tick();
        end
        req = 4'b0000;
    endtask

    initial begin
        test_reset();
        test_single();
        test_all_continuous();
        test_withdraw();
        test_midreset();
        test_hold_req();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

endmodule
